// File: rtl/tag_verify_release_if.sv
// Bus between the receive-side tag gate and its neighbours: tag capture,
// decryption-core results and the authenticated plaintext release.
//
// Handshake semantics:
//   tag_valid        one-cycle strobe; sampled only while the gate is idle,
//                    ignored at all other times.
//   decryption_ready level; the first cycle it is high while the gate is
//                    armed, dec_tag/dec_plain_text are captured. Later high
//                    cycles have no effect.
//   out_valid/ack    out_valid holds the result (and all result outputs are
//                    stable) until ack is sampled high. The gate is then idle
//                    on the next cycle with all outputs at 0. ack while
//                    out_valid is low is ignored.
interface tag_verify_release_if #(
  parameter int y = 40
);
  logic [127:0] expected_tag;
  logic         tag_valid;
  logic [127:0] dec_tag;
  logic [y-1:0] dec_plain_text;
  logic         decryption_ready;
  logic         ack;
  logic [y-1:0] plain_out;
  logic         out_valid;
  logic         auth_ok;
  logic         auth_fail;
  logic         timeout;
  logic         busy;
  logic [2:0]   fsm_state;   // debug view of the gate's FSM state

  modport master (
    output expected_tag, tag_valid, dec_tag, dec_plain_text, decryption_ready, ack,
    input  plain_out, out_valid, auth_ok, auth_fail, timeout, busy, fsm_state
  );

  modport slave (
    input  expected_tag, tag_valid, dec_tag, dec_plain_text, decryption_ready, ack,
    output plain_out, out_valid, auth_ok, auth_fail, timeout, busy, fsm_state
  );
endinterface

// File: rtl/tag_verify_release.sv
// tag_verify_release: authentication gate in front of the plaintext consumer.
// Captures the received tag, waits for the decryption core, compares the
// expected and recomputed tags CHUNK bits per cycle over a fixed N = 128/CHUNK
// cycles (no early exit), and releases plaintext only on a full match.
//
// Optional feature: define TAG_DOUBLE_CHECK_EN to add a second, reversed-order
// comparison pass on complemented operands. A disagreement between the two
// passes is treated as a fault and forces auth_fail.
module tag_verify_release #(
  parameter int y       = 40,
  parameter int CHUNK   = 32,
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst,
  tag_verify_release_if.slave bus
);

  localparam int N  = 128 / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CMP     = 3'd2,
`ifdef TAG_DOUBLE_CHECK_EN
    S_RECHECK = 3'd3,
`endif
    S_DONE    = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [127:0]   exp_q, exp_d;
  logic [127:0]   dec_q, dec_d;
  logic [y-1:0]   pt_q, pt_d;
  logic           diff_acc_q, diff_acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic           tmo_flag_q, tmo_flag_d;
`ifdef TAG_DOUBLE_CHECK_EN
  logic           diff_acc2_q, diff_acc2_d;
`endif

  logic [CHUNK-1:0] exp_chunk;
  logic [CHUNK-1:0] dec_chunk;
  logic             check_fail;
  logic             ok_w;
  logic             done_w;

  // Operand slices for the current chunk index; idx 0 is the LSB chunk.
  assign exp_chunk = exp_q[int'(cnt_q) * CHUNK +: CHUNK];
  assign dec_chunk = dec_q[int'(cnt_q) * CHUNK +: CHUNK];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; compare phases always run their full length.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.tag_valid) state_d = S_ARMED;
      S_ARMED: begin
        if (bus.decryption_ready)                          state_d = S_CMP;
        else if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) state_d = S_DONE;
      end
      S_CMP: begin
        if (cnt_q == IDX_LAST) begin
`ifdef TAG_DOUBLE_CHECK_EN
          state_d = S_RECHECK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef TAG_DOUBLE_CHECK_EN
      S_RECHECK: if (cnt_q == '0) state_d = S_DONE;
`endif
      S_DONE:  if (bus.ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: capture, timeout counting and accumulation.
  always_comb begin
    exp_d      = exp_q;
    dec_d      = dec_q;
    pt_d       = pt_q;
    diff_acc_d = diff_acc_q;
    cnt_d      = cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = tmo_flag_q;
`ifdef TAG_DOUBLE_CHECK_EN
    diff_acc2_d = diff_acc2_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.tag_valid) begin
          exp_d      = bus.expected_tag;
          diff_acc_d = 1'b0;
          cnt_d      = '0;
          tmo_cnt_d  = '0;
          tmo_flag_d = 1'b0;
`ifdef TAG_DOUBLE_CHECK_EN
          diff_acc2_d = 1'b0;
`endif
        end
      end
      S_ARMED: begin
        if (bus.decryption_ready) begin
          dec_d = bus.dec_tag;
          pt_d  = bus.dec_plain_text;
          cnt_d = '0;
        end else if (TIMEOUT != 0) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (tmo_cnt_q == TMO_LAST) tmo_flag_d = 1'b1;
        end
      end
      S_CMP: begin
        diff_acc_d = diff_acc_q | (|(exp_chunk ^ dec_chunk));
        if (cnt_q == IDX_LAST) begin
`ifdef TAG_DOUBLE_CHECK_EN
          // Second pass walks back down from the top chunk.
          cnt_d = IDX_LAST;
`else
          cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef TAG_DOUBLE_CHECK_EN
      S_RECHECK: begin
        diff_acc2_d = diff_acc2_q | (|((~exp_chunk) ^ (~dec_chunk)));
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end
`endif
      S_DONE: begin
        // Drop the held plaintext once the consumer has taken the result.
        if (bus.ack) pt_d = '0;
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q      <= '0;
      dec_q      <= '0;
      pt_q       <= '0;
      diff_acc_q <= 1'b0;
      cnt_q      <= '0;
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
`ifdef TAG_DOUBLE_CHECK_EN
      diff_acc2_q <= 1'b0;
`endif
    end else begin
      exp_q      <= exp_d;
      dec_q      <= dec_d;
      pt_q       <= pt_d;
      diff_acc_q <= diff_acc_d;
      cnt_q      <= cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_flag_q <= tmo_flag_d;
`ifdef TAG_DOUBLE_CHECK_EN
      diff_acc2_q <= diff_acc2_d;
`endif
    end
  end

  // Outputs: only DONE exposes a result; plaintext is gated by auth_ok.
  always_comb begin
`ifdef TAG_DOUBLE_CHECK_EN
    check_fail = tmo_flag_q | diff_acc2_q | (diff_acc_q ^ diff_acc2_q);
`else
    check_fail = tmo_flag_q;
`endif
    done_w        = (state_q == S_DONE);
    ok_w          = done_w & ~diff_acc_q & ~check_fail;
    bus.out_valid = done_w;
    bus.auth_ok   = ok_w;
    bus.auth_fail = done_w & ~ok_w;
    bus.timeout   = done_w & tmo_flag_q;
    bus.plain_out = ok_w ? pt_q : '0;
    bus.busy      = (state_q != S_IDLE);
    bus.fsm_state = state_q;
  end

endmodule

// File: tb/tb_tag_verify_release.sv
// Bench for tag_verify_release: directed steps followed by random
// transactions checked against a tag-equality / timeout reference model.
module tb_tag_verify_release;

  localparam int Y     = 40;
  localparam int CHUNK = 32;
  localparam int N     = 128 / CHUNK;
  localparam int TMO   = 10;
`ifdef TAG_DOUBLE_CHECK_EN
  localparam int LAT = 2 * N;
`else
  localparam int LAT = N;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tag_verify_release_if #(.y(Y)) bus ();

  tag_verify_release #(.y(Y), .CHUNK(CHUNK), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=time_limit_reached expected=finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    check({nm, "/out_valid0"}, bus.out_valid, 0);
    check({nm, "/busy0"},      bus.busy, 0);
    check({nm, "/auth_ok0"},   bus.auth_ok, 0);
    check({nm, "/auth_fail0"}, bus.auth_fail, 0);
    check({nm, "/timeout0"},   bus.timeout, 0);
    check({nm, "/plain0"},     bus.plain_out, 0);
  endtask

  // One transaction. d = number of edges after the tag edge at which ready
  // is first sampled; d > TMO means ready is never raised.
  task automatic do_txn(input string nm, input logic [127:0] et, input logic [127:0] dt,
                        input logic [Y-1:0] pt, input int d,
                        input bit abuse_tv, input bit abuse_ack, input bit ack_tv);
    bit           tmo_m;
    bit           ok_m;
    logic [Y-1:0] pt_m;
    tmo_m = (d > TMO);
    ok_m  = !tmo_m && (et == dt);
    pt_m  = ok_m ? pt : '0;

    bus.expected_tag = et;
    bus.tag_valid    = 1'b1;
    tick();                                   // edge T
    bus.tag_valid    = 1'b0;
    bus.expected_tag = rand128();
    check({nm, "/busy_armed"}, bus.busy, 1);

    if (!tmo_m) begin
      for (int k = 1; k < d; k++) begin
        if (abuse_ack && k == 1) bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
      end
      if (abuse_ack) check({nm, "/busy_after_ack_armed"}, bus.busy, 1);
      bus.decryption_ready = 1'b1;
      bus.dec_tag          = dt;
      bus.dec_plain_text   = pt;
      tick();                                 // edge R
      // Ready stays high with changing data: must not be re-captured.
      bus.dec_tag          = rand128();
      bus.dec_plain_text   = Y'(rand128());
      for (int k = 1; k < LAT; k++) begin
        if (abuse_tv && k == 2) begin
          bus.tag_valid    = 1'b1;
          bus.expected_tag = ~et;
        end
        tick();
        bus.tag_valid = 1'b0;
      end
    end else begin
      for (int k = 1; k < TMO; k++) tick();
    end
    check({nm, "/not_early"}, bus.out_valid, 0);
    tick();
    check({nm, "/out_valid"}, bus.out_valid, 1);
    check({nm, "/auth_ok"},   bus.auth_ok, ok_m);
    check({nm, "/auth_fail"}, bus.auth_fail, !ok_m);
    check({nm, "/timeout"},   bus.timeout, tmo_m);
    check({nm, "/plain"},     bus.plain_out, pt_m);
    bus.decryption_ready = 1'b0;

    tick();
    check({nm, "/hold_valid"}, bus.out_valid, 1);
    check({nm, "/hold_plain"}, bus.plain_out, pt_m);

    bus.ack = 1'b1;
    if (ack_tv) begin
      bus.tag_valid    = 1'b1;
      bus.expected_tag = rand128();
    end
    tick();
    bus.ack       = 1'b0;
    bus.tag_valid = 1'b0;
    check_idle({nm, "/after_ack"});
  endtask

  logic [127:0] tv_tag;
  logic [127:0] rt;
  logic [127:0] rd;
  logic [Y-1:0] rp;
  int           mode;
  int           rdly;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.expected_tag     = '0;
    bus.tag_valid        = 1'b0;
    bus.dec_tag          = '0;
    bus.dec_plain_text   = '0;
    bus.decryption_ready = 1'b0;
    bus.ack              = 1'b0;
    tv_tag = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // Reset state.
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Directed transactions.
    do_txn("match",     tv_tag, tv_tag, 40'hA5A5A5A5A5, 1, 0, 0, 0);
    do_txn("bit127",    tv_tag, tv_tag ^ (128'd1 << 127), 40'hA5A5A5A5A5, 2, 0, 0, 0);
    do_txn("bit0",      tv_tag, tv_tag ^ 128'd1, 40'hA5A5A5A5A5, 2, 0, 0, 0);
    do_txn("timeout",   tv_tag, tv_tag, 40'h1122334455, TMO + 1, 0, 0, 0);
    do_txn("ready_last", tv_tag, tv_tag, 40'h0F0F0F0F0F, TMO, 0, 0, 0);
    do_txn("tv_in_cmp", tv_tag, tv_tag, 40'h5A5A5A5A5A, 1, 1, 0, 0);
    do_txn("ack_armed", tv_tag, tv_tag, 40'h3C3C3C3C3C, 3, 0, 1, 0);
    do_txn("ack_tv",    tv_tag, tv_tag, 40'hC3C3C3C3C3, 1, 0, 0, 1);

    // Ready high while idle changes nothing.
    bus.decryption_ready = 1'b1;
    bus.dec_tag          = tv_tag;
    tick();
    tick();
    tick();
    check_idle("ready_idle");
    bus.decryption_ready = 1'b0;

    // Reset during the third compare cycle.
    bus.expected_tag = tv_tag;
    bus.tag_valid    = 1'b1;
    tick();
    bus.tag_valid        = 1'b0;
    bus.decryption_ready = 1'b1;
    bus.dec_tag          = tv_tag;
    bus.dec_plain_text   = 40'hA5A5A5A5A5;
    tick();                                   // edge R
    tick();
    tick();
    rst = 1'b1;
    tick();                                   // edge R+3
    rst = 1'b0;
    bus.decryption_ready = 1'b0;
    check_idle("rst_mid_cmp");
    do_txn("after_rst", tv_tag, tv_tag, 40'hA5A5A5A5A5, 1, 0, 0, 0);

`ifdef TAG_DOUBLE_CHECK_EN
    // Injected fault in the second pass with matching tags.
    bus.expected_tag = tv_tag;
    bus.tag_valid    = 1'b1;
    tick();
    bus.tag_valid        = 1'b0;
    bus.decryption_ready = 1'b1;
    bus.dec_tag          = tv_tag;
    bus.dec_plain_text   = 40'hA5A5A5A5A5;
    tick();                                   // edge R
    bus.decryption_ready = 1'b0;
    for (int k = 1; k <= N + 1; k++) tick();
    force dut.diff_acc2_q = 1'b1;
    for (int k = N + 2; k < 2 * N; k++) tick();
    check("fault/not_early", bus.out_valid, 0);
    tick();
    check("fault/out_valid", bus.out_valid, 1);
    check("fault/auth_fail", bus.auth_fail, 1);
    check("fault/auth_ok",   bus.auth_ok, 0);
    check("fault/plain",     bus.plain_out, 0);
    release dut.diff_acc2_q;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check_idle("fault/after_ack");
`endif

    // Random transactions.
    for (int i = 0; i < 20; i++) begin
      rt   = rand128();
      rp   = Y'(rand128());
      mode = $urandom_range(0, 2);
      rdly = $urandom_range(1, TMO + 2);
      if (mode == 0)      rd = rt;
      else if (mode == 1) rd = rt ^ (128'd1 << $urandom_range(0, 127));
      else                rd = rand128();
      do_txn($sformatf("rand%0d", i), rt, rd, rp, rdly,
             bit'($urandom_range(0, 1)), 1'b0, bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
